// File: rtl/lfclk_axil_cfg_sequencer_if.sv
// lfclk_axil_cfg_sequencer_if: AXI4-Lite bundle between the config sequencer and the clock generator slave
interface lfclk_axil_cfg_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/lfclk_axil_cfg_sequencer.sv
// lfclk_axil_cfg_sequencer: AXI4-Lite master that writes the clock generator config words, then reads them back to verify
module lfclk_axil_cfg_sequencer #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_REGS         = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int                            C_TIMEOUT          = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [32*C_NUM_REGS-1:0] cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [3:0]              err_idx,
    lfclk_axil_cfg_sequencer_if.master m_axi
);
    localparam int TW = $clog2(C_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, ERR} state_t;

    state_t                  state, nxt;
    logic [32*C_NUM_REGS-1:0] cfg_q;
    logic [3:0]              idx;
    logic [TW-1:0]           tcnt;
    logic                    aw_ok, w_ok, last, wait_st;
    logic [1:0]              code;
    logic [31:0]             word;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;

    assign last    = idx == 4'(C_NUM_REGS - 1);
    assign word    = cfg_q[32*idx +: 32];
    assign addr    = C_BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(idx) << 2);
    assign wait_st = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};

    always_ff @(posedge ACLK) state <= ARESET ? IDLE : nxt;

    always_comb begin
        nxt  = state;
        code = 2'd3;
        unique case (state)
            IDLE:    nxt = start ? WR_REQ : IDLE;
            WR_REQ:  nxt = (aw_ok || m_axi.awready) && (w_ok || m_axi.wready) ? WR_RESP : WR_REQ;
            WR_RESP: if (m_axi.bvalid) begin
                nxt  = m_axi.bresp != 2'b00 ? ERR : last ? RD_REQ : WR_REQ;
                code = 2'd0;
            end
            RD_REQ:  nxt = m_axi.arready ? RD_RESP : RD_REQ;
            RD_RESP: if (m_axi.rvalid) begin
                nxt  = m_axi.rresp != 2'b00 || m_axi.rdata != C_M_AXI_DATA_WIDTH'(word) ? ERR : last ? DONE : RD_REQ;
                code = m_axi.rresp != 2'b00 ? 2'd1 : 2'd2;
            end
            default: nxt = IDLE;
        endcase
        // A stalled handshake overrides staying put; outstanding valids fall with the move to ERR
        if (wait_st && nxt == state && tcnt == TW'(C_TIMEOUT - 1)) begin
            nxt  = ERR;
            code = 2'd3;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cfg_q    <= '0;
            idx      <= '0;
            tcnt     <= '0;
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
            err_code <= '0;
            err_idx  <= '0;
        end else begin
            if (state == IDLE && start) begin
                cfg_q    <= cfg_data;
                err_code <= '0;
                err_idx  <= '0;
            end
            if (nxt == ERR && state != ERR) begin
                err_code <= code;
                err_idx  <= idx;
            end
            idx   <= state == IDLE ? '0 :
                     (state == WR_RESP && nxt == WR_REQ) || (state == RD_RESP && nxt == RD_REQ) ? idx + 4'd1 :
                     state == WR_RESP && nxt == RD_REQ ? '0 : idx;
            tcnt  <= !wait_st || nxt != state ? '0 : tcnt + 1'b1;
            aw_ok <= state == WR_REQ && (aw_ok || m_axi.awready);
            w_ok  <= state == WR_REQ && (w_ok || m_axi.wready);
        end
    end

    always_comb begin
        busy          = state != IDLE;
        done          = state == DONE;
        error         = state == ERR;
        m_axi.awaddr  = addr;
        m_axi.awprot  = 3'b000;
        m_axi.awvalid = state == WR_REQ && !aw_ok;
        m_axi.wdata   = C_M_AXI_DATA_WIDTH'(word);
        m_axi.wstrb   = '1;
        m_axi.wvalid  = state == WR_REQ && !w_ok;
        m_axi.bready  = state == WR_RESP;
        m_axi.araddr  = addr;
        m_axi.arprot  = 3'b000;
        m_axi.arvalid = state == RD_REQ;
        m_axi.rready  = state == RD_RESP;
    end
endmodule
